// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg
// Shared types and constants for the NES CPU memory responder.
//   mem_state_t      : responder FSM states
//   WRAM_AW          : work-RAM index width (2 KiB)
//   WRAM_SIZE        : work-RAM depth in bytes
//   WRAM_REGION_MASK : address bits that must be zero for a work-RAM hit
//   is_wram()        : true when a CPU address falls in $0000-$1FFF
package nes_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    EXT      = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

  localparam int          WRAM_AW          = 11;
  localparam int          WRAM_SIZE        = 2048;
  localparam logic [15:0] WRAM_REGION_MASK = 16'hE000;

  // The 2 KiB RAM is mirrored four times across the bottom 8 KiB, so only
  // the top three address bits decide whether an access is internal.
  function automatic logic is_wram(input logic [15:0] addr);
    return (addr & WRAM_REGION_MASK) == 16'h0000;
  endfunction

endpackage

// File: rtl/cpu_wram.sv
// cpu_wram
// 2048 x 8 single-port synchronous work RAM.
//   clk   : clock
//   en    : access enable; rdata only changes on an enabled edge
//   we    : write enable (qualified by en)
//   addr  : byte index
//   wdata : write data
//   rdata : registered read data; a write returns the new data
module cpu_wram
  import nes_mem_pkg::*;
(
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [WRAM_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [WRAM_SIZE];

  // Single port: an enabled edge either writes (and forwards the written
  // byte to rdata) or reads. rdata holds between accesses so the parent
  // can use it as a stable open-bus source.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/nes_cpu_mem_resp.sv
// nes_cpu_mem_resp
// Memory-side responder for the NES CPU bus. Serves the mirrored 2 KiB
// work RAM directly and forwards every other address to an external
// request/acknowledge port (PPU, APU, cartridge glue). Inserts wait states
// by dropping rdy and keeps the last transferred byte as the open-bus value.
//   clk, rst            : clock, asynchronous active-low reset
//   addr_out, data_out  : CPU address and write data
//   ren, wen            : CPU read / write request (write wins if both)
//   data_in             : read data / open-bus value to the CPU
//   rdy                 : high = can accept or has completed an access
//   ext_req/ext_we      : external access pending / is a write
//   ext_addr/ext_wdata  : latched external address / write data
//   ext_rdata/ext_ack   : external read data / completion strobe
//   bus_err             : sticky, set when an external access times out
module nes_cpu_mem_resp
  import nes_mem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int EXT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_out,
  input  logic [7:0]  data_out,
  input  logic        ren,
  input  logic        wen,
  output logic [7:0]  data_in,
  output logic        rdy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  localparam bit               ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]       WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam int               TMO_W     = $clog2(EXT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(EXT_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;

  mem_state_t       state;
  logic [3:0]       wait_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             acc_we;
  logic [7:0]       bus_q;
  logic             sel_ram;

  logic             req;
  logic             req_wram;
  logic             ram_en;
  logic             ram_we;
  logic [7:0]       ram_rdata;

  assign req      = ren | wen;
  assign req_wram = is_wram(addr_out);

  // The RAM is touched only on the edge that completes an access: the
  // accepting edge with no wait states, or the last RAM_WAIT edge. The CPU
  // holds its address and data stable while rdy is low, so they feed the
  // RAM directly; the write/read choice is latched at acceptance.
  assign ram_en = ((state == IDLE) && req && req_wram && ZERO_WAIT) ||
                  ((state == RAM_WAIT) && (wait_cnt == 4'd0));
  assign ram_we = (state == RAM_WAIT) ? acc_we : wen;

  cpu_wram u_wram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_out[WRAM_AW-1:0]),
    .wdata (data_out),
    .rdata (ram_rdata)
  );

  // Open-bus value: the RAM's output register holds the last RAM transfer,
  // bus_q holds the last external transfer, and the registered sel_ram
  // picks whichever happened most recently. Both sources and the select
  // are flops, so data_in never depends on live CPU inputs.
  assign data_in = sel_ram ? ram_rdata : bus_q;

  // Responder FSM. IDLE accepts a request; zero-wait RAM completes in
  // place, otherwise RAM_WAIT counts down or EXT waits for ext_ack /
  // timeout. DONE is a mandatory one-cycle gap so the CPU can drop or
  // change its request before the next acceptance. ext_ack outside EXT is
  // simply not looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      tmo_cnt   <= '0;
      acc_we    <= 1'b0;
      bus_q     <= 8'h00;
      sel_ram   <= 1'b0;
      rdy       <= 1'b1;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (req_wram) begin
              if (ZERO_WAIT) begin
                sel_ram <= 1'b1;
              end else begin
                rdy      <= 1'b0;
                wait_cnt <= WAIT_LOAD;
                acc_we   <= wen;
                state    <= RAM_WAIT;
              end
            end else begin
              ext_req   <= 1'b1;
              ext_we    <= wen;
              ext_addr  <= addr_out;
              ext_wdata <= data_out;
              rdy       <= 1'b0;
              tmo_cnt   <= '0;
              state     <= EXT;
            end
          end
        end
        RAM_WAIT: begin
          if (wait_cnt == 4'd0) begin
            sel_ram <= 1'b1;
            rdy     <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        EXT: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            rdy     <= 1'b1;
            sel_ram <= 1'b0;
            bus_q   <= ext_we ? data_out : ext_rdata;
            state   <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the access; data_in keeps its old open-bus value.
            ext_req <= 1'b0;
            bus_err <= 1'b1;
            rdy     <= 1'b1;
            state   <= DONE;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_cpu_mem_resp.sv
// tb_nes_cpu_mem_resp
// Two responders: dut0 with no wait states, dut1 with WAIT_STATES=3 and
// EXT_TIMEOUT=8. Directed accesses push their expected completion into a
// per-DUT queue; monitors pop and compare when each DUT completes.
module tb_nes_cpu_mem_resp;

  typedef struct {
    string      name;
    logic [7:0] data;
    int         low;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rst;

  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ren0, wen0, ren1, wen1;
  logic [7:0]  data_in0, data_in1;
  logic        rdy0, rdy1;
  logic        ext_req0, ext_req1;
  logic        ext_we0, ext_we1;
  logic [15:0] ext_addr0, ext_addr1;
  logic [7:0]  ext_wdata0, ext_wdata1;
  logic [7:0]  ext_rdata0, ext_rdata1;
  logic        ext_ack0, ext_ack1;
  logic        bus_err0, bus_err1;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_at   = 0;
  logic [7:0]  ack_data = 8'h00;
  bit          force_ack = 1'b0;
  bit          norm_ack  = 1'b0;
  bit          rdy0_low_seen = 1'b0;

  nes_cpu_mem_resp #(.WAIT_STATES(0), .EXT_TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .addr_out(addr0), .data_out(wdata0),
    .ren(ren0), .wen(wen0), .data_in(data_in0), .rdy(rdy0),
    .ext_req(ext_req0), .ext_we(ext_we0), .ext_addr(ext_addr0),
    .ext_wdata(ext_wdata0), .ext_rdata(ext_rdata0), .ext_ack(ext_ack0),
    .bus_err(bus_err0)
  );

  nes_cpu_mem_resp #(.WAIT_STATES(3), .EXT_TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .addr_out(addr1), .data_out(wdata1),
    .ren(ren1), .wen(wen1), .data_in(data_in1), .rdy(rdy1),
    .ext_req(ext_req1), .ext_we(ext_we1), .ext_addr(ext_addr1),
    .ext_wdata(ext_wdata1), .ext_rdata(ext_rdata1), .ext_ack(ext_ack1),
    .bus_err(bus_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push1(input string name, input logic [7:0] d, input int low,
                       input logic err);
    exp_t e;
    e.name = name;
    e.data = d;
    e.low  = low;
    e.err  = err;
    q1.push_back(e);
  endtask

  // dut0 access held for exactly one accepting edge.
  task automatic apply_stimulus0(input string name, input logic we,
                                 input logic [15:0] a, input logic [7:0] d,
                                 input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.data = exp;
    e.low  = 0;
    e.err  = 1'b0;
    @(negedge clk);
    q0.push_back(e);
    addr0  = a;
    wdata0 = d;
    wen0   = we;
    ren0   = !we;
  endtask

  task automatic start1(input string name, input logic we,
                        input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input int low, input logic err);
    @(negedge clk);
    push1(name, exp, low, err);
    addr1  = a;
    wdata1 = d;
    wen1   = we;
    ren1   = !we;
  endtask

  // Returns at the negedge where rdy1 is seen rising after a low period.
  task automatic wait_done1(input string name);
    bit seen_low;
    bit ok;
    seen_low = 1'b0;
    ok       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rdy1) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s completion: rdy=%b after 40 cycles, expected rise", name, rdy1);
    end
  endtask

  task automatic apply_stimulus1(input string name, input logic we,
                                 input logic [15:0] a, input logic [7:0] d,
                                 input logic [7:0] exp, input int low,
                                 input logic err);
    start1(name, we, a, d, exp, low, err);
    wait_done1(name);
    ren1 = 1'b0;
    wen1 = 1'b0;
  endtask

  // dut0 monitor: a request present at a posedge completes by the next negedge.
  initial begin
    bit p;
    forever begin
      @(posedge clk);
      p = rst && (ren0 || wen0);
      @(negedge clk);
      if (p) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL dut0 unexpected completion: data %h, expected none", data_in0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          check_output({e.name, " data"}, {8'h00, data_in0}, {8'h00, e.data});
        end
      end
      if (rst && !rdy0) rdy0_low_seen = 1'b1;
    end
  end

  // dut1 monitor: completion is rdy rising; also measures the low period.
  initial begin
    int low;
    bit prev;
    low  = 0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        low  = 0;
        prev = 1'b1;
      end else begin
        if (!rdy1) low++;
        else if (!prev) begin
          if (q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL dut1 unexpected completion: data %h, expected none", data_in1);
          end else begin
            exp_t e;
            e = q1.pop_front();
            check_output({e.name, " data"}, {8'h00, data_in1}, {8'h00, e.data});
            check_output({e.name, " rdy low cycles"}, 16'(low), 16'(e.low));
            check_output({e.name, " bus_err"}, {15'h0, bus_err1}, {15'h0, e.err});
          end
          low = 0;
        end
        prev = rdy1;
      end
    end
  end

  // External-side responder for dut1: acks on the ack_at-th cycle of ext_req.
  initial begin
    int cnt;
    cnt        = 0;
    ext_ack1   = 1'b0;
    ext_rdata1 = 8'h00;
    forever begin
      @(negedge clk);
      if (norm_ack) begin
        norm_ack = 1'b0;
        cnt      = 0;
      end else if (rst && ext_req1 && ack_at > 0) begin
        cnt++;
        if (cnt == ack_at) norm_ack = 1'b1;
      end else begin
        cnt = 0;
      end
      ext_ack1   = norm_ack | force_ack;
      ext_rdata1 = force_ack ? 8'hAA : ack_data;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    rst = 1'b1;
    addr0 = 16'h0000; wdata0 = 8'h00; ren0 = 1'b0; wen0 = 1'b0;
    addr1 = 16'h0000; wdata1 = 8'h00; ren1 = 1'b0; wen1 = 1'b0;
    ext_rdata0 = 8'h00; ext_ack0 = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    check_output("reset data_in", {8'h00, data_in1}, 16'h0000);
    check_output("reset rdy", {15'h0, rdy1}, 16'h0001);
    check_output("reset ext_req", {15'h0, ext_req1}, 16'h0000);
    check_output("reset ext_we", {15'h0, ext_we1}, 16'h0000);
    check_output("reset ext_addr", ext_addr1, 16'h0000);
    check_output("reset ext_wdata", {8'h00, ext_wdata1}, 16'h0000);
    check_output("reset bus_err", {15'h0, bus_err1}, 16'h0000);
    check_output("reset dut0 data_in", {8'h00, data_in0}, 16'h0000);
    check_output("reset dut0 rdy", {15'h0, rdy0}, 16'h0001);

    // Zero-wait RAM, including mirror aliases and back-to-back accesses.
    apply_stimulus0("z wr 0123", 1'b1, 16'h0123, 8'h5A, 8'h5A);
    apply_stimulus0("z rd 0923", 1'b0, 16'h0923, 8'h00, 8'h5A);
    apply_stimulus0("z wr 0000", 1'b1, 16'h0000, 8'h11, 8'h11);
    apply_stimulus0("z rd 1800", 1'b0, 16'h1800, 8'h00, 8'h11);
    apply_stimulus0("z rd 1123", 1'b0, 16'h1123, 8'h00, 8'h5A);
    @(negedge clk);
    ren0 = 1'b0;
    wen0 = 1'b0;

    // Wait-state RAM and the DONE gap before the next acceptance.
    apply_stimulus1("w wr 07FF", 1'b1, 16'h07FF, 8'h3C, 8'h3C, 3, 1'b0);
    start1("w rd 07FF", 1'b0, 16'h07FF, 8'h00, 8'h3C, 3, 1'b0);
    wait_done1("w rd 07FF");
    addr1 = 16'h0FFF;
    push1("w rd 0FFF", 8'h3C, 3, 1'b0);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy1) gap++;
      else break;
    end
    check_output("done gap cycles", 16'(gap), 16'd1);
    wait_done1("w rd 0FFF");
    ren1 = 1'b0;

    // External read acked on the 5th edge after acceptance.
    ack_at   = 5;
    ack_data = 8'h80;
    start1("ext rd 2002", 1'b0, 16'h2002, 8'h00, 8'h80, 5, 1'b0);
    @(negedge clk);
    check_output("ext rd ext_req", {15'h0, ext_req1}, 16'h0001);
    check_output("ext rd ext_we", {15'h0, ext_we1}, 16'h0000);
    check_output("ext rd ext_addr", ext_addr1, 16'h2002);
    wait_done1("ext rd 2002");
    ren1 = 1'b0;
    check_output("ext rd ext_req after ack", {15'h0, ext_req1}, 16'h0000);

    // External write.
    ack_at = 3;
    start1("ext wr 4014", 1'b1, 16'h4014, 8'hC3, 8'hC3, 3, 1'b0);
    @(negedge clk);
    check_output("ext wr ext_we", {15'h0, ext_we1}, 16'h0001);
    check_output("ext wr ext_wdata", {8'h00, ext_wdata1}, 16'h00C3);
    check_output("ext wr ext_addr", ext_addr1, 16'h4014);
    wait_done1("ext wr 4014");
    wen1 = 1'b0;

    // Timeout: no ack, open bus keeps $C3, bus_err sets and sticks.
    ack_at = 0;
    start1("ext rd 5000 timeout", 1'b0, 16'h5000, 8'h00, 8'hC3, 8, 1'b1);
    @(negedge clk);
    check_output("timeout ext_req pending", {15'h0, ext_req1}, 16'h0001);
    wait_done1("ext rd 5000 timeout");
    ren1 = 1'b0;
    check_output("timeout ext_req dropped", {15'h0, ext_req1}, 16'h0000);
    apply_stimulus1("w rd 07FF sticky err", 1'b0, 16'h07FF, 8'h00, 8'h3C, 3, 1'b1);

    // Reset in the middle of an external access, then a stray ack.
    @(negedge clk);
    addr1 = 16'h6000;
    ren1  = 1'b1;
    repeat (3) @(negedge clk);
    check_output("pre-reset ext_req", {15'h0, ext_req1}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    check_output("reset ext_req async", {15'h0, ext_req1}, 16'h0000);
    check_output("reset rdy async", {15'h0, rdy1}, 16'h0001);
    check_output("reset bus_err cleared", {15'h0, bus_err1}, 16'h0000);
    ren1 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check_output("stray ack ext_req", {15'h0, ext_req1}, 16'h0000);
    check_output("stray ack rdy", {15'h0, rdy1}, 16'h0001);
    check_output("stray ack data_in", {8'h00, data_in1}, 16'h0000);
    check_output("stray ack bus_err", {15'h0, bus_err1}, 16'h0000);

    // RAM contents survive reset; $1FFF aliases $07FF.
    apply_stimulus1("w rd 1FFF post reset", 1'b0, 16'h1FFF, 8'h00, 8'h3C, 3, 1'b0);

    repeat (3) @(negedge clk);
    check_output("dut0 queue drained", 16'(q0.size()), 16'd0);
    check_output("dut1 queue drained", 16'(q1.size()), 16'd0);
    check_output("dut0 rdy stayed high", {15'h0, rdy0_low_seen}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
